seg_day_encoder: RTL

Reverse direction of the day-display segment decoder: accepts a 7-bit A..G segment pattern from a panel scanner, debounces it until stable, and encodes it back to the 5-bit day code (0..16). It sits between the segment-scan front end and the day-tracking logic, delivering one code per stable pattern over a valid/ready handshake and flagging unrecognised patterns.

---
 rtl/seg_day_pkg.sv | 33 +++
 rtl/seg_day_lookup.sv | 34 +++
 rtl/seg_day_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_day_pkg.sv
// Shared constants, pattern table and FSM state type for the day-code segment encoder.
package seg_day_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [4:0] CODE_INVALID = 5'h1F;

  // Segment order A..G, bit 6 = A. Code 4 shares PAT_D01 and has no entry of its own.
  localparam logic [6:0] PAT_D00 = 7'b1100110;
  localparam logic [6:0] PAT_D01 = 7'b1110000;
  localparam logic [6:0] PAT_D02 = 7'b0011101;
  localparam logic [6:0] PAT_D03 = 7'b1110110;
  localparam logic [6:0] PAT_D05 = 7'b1000000;
  localparam logic [6:0] PAT_D06 = 7'b0111110;
  localparam logic [6:0] PAT_D07 = 7'b1001111;
  localparam logic [6:0] PAT_D08 = 7'b0011110;
  localparam logic [6:0] PAT_D09 = 7'b1111000;
  localparam logic [6:0] PAT_D10 = 7'b1111001;
  localparam logic [6:0] PAT_D11 = 7'b0110111;
  localparam logic [6:0] PAT_D12 = 7'b1000111;
  localparam logic [6:0] PAT_D13 = 7'b0000101;
  localparam logic [6:0] PAT_D14 = 7'b0000110;
  localparam logic [6:0] PAT_D15 = 7'b1011011;
  localparam logic [6:0] PAT_D16 = 7'b1110111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    WAIT_CHANGE
  } state_t;

endpackage

// File: rtl/seg_day_lookup.sv
// Combinational segment-pattern to day-code ROM; unknown patterns give CODE_INVALID with err set.
module seg_day_lookup
  import seg_day_pkg::*;
(
  input  logic [6:0] pat,
  output logic [4:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_INVALID;
    err  = 1'b0;
    case (pat)
      PAT_D00: code = 5'd0;
      PAT_D01: code = 5'd1;
      PAT_D02: code = 5'd2;
      PAT_D03: code = 5'd3;
      PAT_D05: code = 5'd5;
      PAT_D06: code = 5'd6;
      PAT_D07: code = 5'd7;
      PAT_D08: code = 5'd8;
      PAT_D09: code = 5'd9;
      PAT_D10: code = 5'd10;
      PAT_D11: code = 5'd11;
      PAT_D12: code = 5'd12;
      PAT_D13: code = 5'd13;
      PAT_D14: code = 5'd14;
      PAT_D15: code = 5'd15;
      PAT_D16: code = 5'd16;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_day_encoder.sv
// Debounces a 7-segment pattern and emits its day code once per stable pattern over valid/ready.
// Optional feature: define SEG_DAY_ENC_DEDUP_EN to suppress results equal to the last one emitted.
module seg_day_encoder
  import seg_day_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       in_valid,
  output logic [4:0] out_code,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  state_t     state, state_d;
  logic [6:0] ref_pat, ref_d;
  logic [7:0] cnt, cnt_d;
  logic [4:0] code_d;
  logic       err_d;
  logic       valid_d;

  logic [4:0] lut_code;
  logic       lut_err;
  logic       dup;

  seg_day_lookup u_lookup (
    .pat  (ref_pat),
    .code (lut_code),
    .err  (lut_err)
  );

`ifdef SEG_DAY_ENC_DEDUP_EN
  logic [4:0] last_code;
  logic       last_err;
  logic       last_vld;

  assign dup = last_vld && (last_code == lut_code) && (last_err == lut_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code <= 5'h00;
      last_err  <= 1'b0;
      last_vld  <= 1'b0;
    end else if (state == HOLD && out_ready) begin
      last_code <= out_code;
      last_err  <= out_err;
      last_vld  <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ref_pat   <= 7'h00;
      cnt       <= 8'h00;
      out_code  <= 5'h00;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      ref_pat   <= ref_d;
      cnt       <= cnt_d;
      out_code  <= code_d;
      out_err   <= err_d;
      out_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    ref_d   = ref_pat;
    cnt_d   = cnt;
    code_d  = out_code;
    err_d   = out_err;
    valid_d = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ref_d   = seg_in;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!in_valid) begin
          state_d = IDLE;
        end else if (seg_in != ref_pat) begin
          ref_d = seg_in;
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt + 8'd1;
          // ref already equals seg_in here, so the ROM output is the settled result
          if (cnt_d == STABLE_LIM) begin
            if (dup) begin
              state_d = WAIT_CHANGE;
            end else begin
              code_d  = lut_code;
              err_d   = lut_err;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_CHANGE;
        end
      end
      WAIT_CHANGE: begin
        if (!in_valid) begin
          state_d = IDLE;
        end else if (seg_in != ref_pat) begin
          ref_d   = seg_in;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
